// File: rtl/kmeans_centroid_update.sv
// K-means centroid update unit.
// Accumulates classified points into per-cluster sums and counts, then on an
// epoch-end pulse divides each sum by its count (two restoring dividers in
// parallel, one quotient bit per cycle) and emits one centroid per cluster.
// Handshake: there is no back-pressure. A point is taken on any cycle where
// pt_valid is high while busy is low; cent_valid and update_done are one-cycle
// pulses that the consumer must capture when they are high.
module kmeans_centroid_update #(
   parameter int K     = 4,
   parameter int DW    = 16,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] pt_x,
   input  logic [DW-1:0] pt_y,
   input  logic [1:0]    pt_cluster,
   input  logic          pt_valid,
   input  logic          epoch_done,
   output logic          busy,
   output logic          cent_valid,
   output logic [1:0]    cent_idx,
   output logic [DW-1:0] cent_x,
   output logic [DW-1:0] cent_y,
   output logic          cent_empty,
   output logic          update_done,
   output logic          overflow
);

   localparam int SW = DW + CNT_W;          // sum width, also divider iterations
   localparam int IW = $clog2(SW + 1);
   localparam logic [2:0] K_LIM    = 3'(K);
   localparam logic [1:0] LAST_IDX = 2'(K - 1);

   typedef enum logic [2:0] {ST_ACCUM, ST_LOAD, ST_DIV, ST_EMIT, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [SW-1:0]      sum_x_q [K];
   logic [SW-1:0]      sum_x_d [K];
   logic [SW-1:0]      sum_y_q [K];
   logic [SW-1:0]      sum_y_d [K];
   logic [CNT_W-1:0]   cnt_q [K];
   logic [CNT_W-1:0]   cnt_d [K];
   // Dividend registers shift left and fill with quotient bits from the right.
   logic [SW-1:0]      dvd_x_q, dvd_x_d, dvd_y_q, dvd_y_d;
   logic [CNT_W-1:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
   logic [CNT_W-1:0]   dvs_q, dvs_d;
   logic [IW-1:0]      iter_q, iter_d;
   logic               busy_q, busy_d;
   logic               cent_valid_q, cent_valid_d;
   logic [1:0]         cent_idx_q, cent_idx_d;
   logic [DW-1:0]      cent_x_q, cent_x_d, cent_y_q, cent_y_d;
   logic               cent_empty_q, cent_empty_d;
   logic               update_done_q, update_done_d;
   logic               overflow_q, overflow_d;
   logic [SW-1:0]      sel_sx, sel_sy;
   logic [CNT_W-1:0]   sel_cnt;

   // One restoring-division step: returns {new remainder, shifted dividend}.
   // The remainder stays below the divisor, so the trial value fits CNT_W+1 bits.
   function automatic logic [CNT_W+SW-1:0] div_step(input logic [SW-1:0]    dvd,
                                                    input logic [CNT_W-1:0] rem,
                                                    input logic [CNT_W-1:0] dvs);
      logic [CNT_W:0] trial;
      logic           qbit;
      trial = {rem, dvd[SW-1]};
      qbit  = 1'b0;
      if (trial >= {1'b0, dvs}) begin
         trial = trial - {1'b0, dvs};
         qbit  = 1'b1;
      end
      return {trial[CNT_W-1:0], dvd[SW-2:0], qbit};
   endfunction

   // Select the accumulators of the cluster currently being processed.
   always_comb begin
      sel_sx  = '0;
      sel_sy  = '0;
      sel_cnt = '0;
      for (int k = 0; k < K; k++) begin
         if (idx_q == 2'(k)) begin
            sel_sx  = sum_x_q[k];
            sel_sy  = sum_y_q[k];
            sel_cnt = cnt_q[k];
         end
      end
   end

   // Next-state, accumulator, divider and output computation.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      sum_x_d       = sum_x_q;
      sum_y_d       = sum_y_q;
      cnt_d         = cnt_q;
      dvd_x_d       = dvd_x_q;
      dvd_y_d       = dvd_y_q;
      rem_x_d       = rem_x_q;
      rem_y_d       = rem_y_q;
      dvs_d         = dvs_q;
      iter_d        = iter_q;
      cent_valid_d  = 1'b0;
      cent_idx_d    = cent_idx_q;
      cent_x_d      = cent_x_q;
      cent_y_d      = cent_y_q;
      cent_empty_d  = cent_empty_q;
      update_done_d = 1'b0;
      overflow_d    = overflow_q;
      case (state_q)
         ST_ACCUM: begin
            // A point arriving with epoch_done still belongs to this epoch.
            if (pt_valid && ({1'b0, pt_cluster} < K_LIM)) begin
               for (int k = 0; k < K; k++) begin
                  if (pt_cluster == 2'(k)) begin
                     if (&cnt_q[k]) begin
                        overflow_d = 1'b1;
                     end else begin
                        sum_x_d[k] = sum_x_q[k] + {{CNT_W{1'b0}}, pt_x};
                        sum_y_d[k] = sum_y_q[k] + {{CNT_W{1'b0}}, pt_y};
                        cnt_d[k]   = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
                     end
                  end
               end
            end
            if (epoch_done) begin
               state_d = ST_LOAD;
               idx_d   = 2'd0;
            end
         end
         ST_LOAD: begin
            dvd_x_d = sel_sx;
            dvd_y_d = sel_sy;
            dvs_d   = sel_cnt;
            rem_x_d = '0;
            rem_y_d = '0;
            iter_d  = '0;
            if (sel_cnt == '0) begin
               state_d      = ST_EMIT;
               cent_valid_d = 1'b1;
               cent_idx_d   = idx_q;
               cent_empty_d = 1'b1;
               cent_x_d     = '0;
               cent_y_d     = '0;
            end else begin
               state_d = ST_DIV;
            end
         end
         ST_DIV: begin
            {rem_x_d, dvd_x_d} = div_step(dvd_x_q, rem_x_q, dvs_q);
            {rem_y_d, dvd_y_d} = div_step(dvd_y_q, rem_y_q, dvs_q);
            iter_d = iter_q + 1'b1;
            if (iter_q == IW'(SW - 1)) begin
               state_d      = ST_EMIT;
               cent_valid_d = 1'b1;
               cent_idx_d   = idx_q;
               cent_empty_d = 1'b0;
               cent_x_d     = dvd_x_d[DW-1:0];
               cent_y_d     = dvd_y_d[DW-1:0];
            end
         end
         ST_EMIT: begin
            if (idx_q == LAST_IDX) begin
               state_d       = ST_DONE;
               update_done_d = 1'b1;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            sum_x_d = '{default: '0};
            sum_y_d = '{default: '0};
            cnt_d   = '{default: '0};
            state_d = ST_ACCUM;
         end
         default: state_d = ST_ACCUM;
      endcase
      busy_d = (state_d != ST_ACCUM);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_ACCUM;
         idx_q         <= '0;
         sum_x_q       <= '{default: '0};
         sum_y_q       <= '{default: '0};
         cnt_q         <= '{default: '0};
         dvd_x_q       <= '0;
         dvd_y_q       <= '0;
         rem_x_q       <= '0;
         rem_y_q       <= '0;
         dvs_q         <= '0;
         iter_q        <= '0;
         busy_q        <= 1'b0;
         cent_valid_q  <= 1'b0;
         cent_idx_q    <= '0;
         cent_x_q      <= '0;
         cent_y_q      <= '0;
         cent_empty_q  <= 1'b0;
         update_done_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         sum_x_q       <= sum_x_d;
         sum_y_q       <= sum_y_d;
         cnt_q         <= cnt_d;
         dvd_x_q       <= dvd_x_d;
         dvd_y_q       <= dvd_y_d;
         rem_x_q       <= rem_x_d;
         rem_y_q       <= rem_y_d;
         dvs_q         <= dvs_d;
         iter_q        <= iter_d;
         busy_q        <= busy_d;
         cent_valid_q  <= cent_valid_d;
         cent_idx_q    <= cent_idx_d;
         cent_x_q      <= cent_x_d;
         cent_y_q      <= cent_y_d;
         cent_empty_q  <= cent_empty_d;
         update_done_q <= update_done_d;
         overflow_q    <= overflow_d;
      end
   end

   assign busy        = busy_q;
   assign cent_valid  = cent_valid_q;
   assign cent_idx    = cent_idx_q;
   assign cent_x      = cent_x_q;
   assign cent_y      = cent_y_q;
   assign cent_empty  = cent_empty_q;
   assign update_done = update_done_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Bench for kmeans_centroid_update: default instance, a CNT_W=2 instance for
// count saturation and a K=3 instance for out-of-range cluster indices.
module tb_kmeans_centroid_update;
   localparam int EW = 68;  // {kind, idx, empty, x, y, cycle}

   logic        clk = 1'b0;
   logic [2:0]  rst_v, pv, ep;
   logic [15:0] pt_x, pt_y;
   logic [1:0]  pt_cl;

   logic        a_busy, a_cv, a_emp, a_ud, a_ov;
   logic [1:0]  a_idx;
   logic [15:0] a_x, a_y;
   logic        b_busy, b_cv, b_emp, b_ud, b_ov;
   logic [1:0]  b_idx;
   logic [15:0] b_x, b_y;
   logic        c_busy, c_cv, c_emp, c_ud, c_ov;
   logic [1:0]  c_idx;
   logic [15:0] c_x, c_y;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_qa[$];
   logic [EW-1:0] exp_qb[$];
   logic [EW-1:0] exp_qc[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kmeans_centroid_update u_a (
      .clk(clk), .rst(rst_v[0]), .pt_x(pt_x), .pt_y(pt_y), .pt_cluster(pt_cl),
      .pt_valid(pv[0]), .epoch_done(ep[0]), .busy(a_busy), .cent_valid(a_cv),
      .cent_idx(a_idx), .cent_x(a_x), .cent_y(a_y), .cent_empty(a_emp),
      .update_done(a_ud), .overflow(a_ov));

   kmeans_centroid_update #(.CNT_W(2)) u_b (
      .clk(clk), .rst(rst_v[1]), .pt_x(pt_x), .pt_y(pt_y), .pt_cluster(pt_cl),
      .pt_valid(pv[1]), .epoch_done(ep[1]), .busy(b_busy), .cent_valid(b_cv),
      .cent_idx(b_idx), .cent_x(b_x), .cent_y(b_y), .cent_empty(b_emp),
      .update_done(b_ud), .overflow(b_ov));

   kmeans_centroid_update #(.K(3)) u_c (
      .clk(clk), .rst(rst_v[2]), .pt_x(pt_x), .pt_y(pt_y), .pt_cluster(pt_cl),
      .pt_valid(pv[2]), .epoch_done(ep[2]), .busy(c_busy), .cent_valid(c_cv),
      .cent_idx(c_idx), .cent_x(c_x), .cent_y(c_y), .cent_empty(c_emp),
      .update_done(c_ud), .overflow(c_ov));

   // ---------------- scoreboard ----------------
   function automatic int qsize(input int inst);
      case (inst)
         0:       return exp_qa.size();
         1:       return exp_qb.size();
         default: return exp_qc.size();
      endcase
   endfunction

   task automatic push_ev(input int inst, input logic kind, input logic [1:0] idx,
                          input logic emp, input logic [15:0] x, input logic [15:0] y,
                          input int at);
      logic [EW-1:0] e;
      e = {kind, idx, emp, x, y, 32'(at)};
      case (inst)
         0:       exp_qa.push_back(e);
         1:       exp_qb.push_back(e);
         default: exp_qc.push_back(e);
      endcase
   endtask

   task automatic exp_cent(input int inst, input logic [1:0] idx, input logic [15:0] x,
                           input logic [15:0] y, input int at);
      push_ev(inst, 1'b0, idx, 1'b0, x, y, at);
   endtask

   task automatic exp_empty(input int inst, input logic [1:0] idx, input int at);
      push_ev(inst, 1'b0, idx, 1'b1, 16'h0, 16'h0, at);
   endtask

   task automatic exp_done(input int inst, input int at);
      push_ev(inst, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, at);
   endtask

   task automatic check_ev(input int inst, input logic kind, input logic [1:0] idx,
                           input logic emp, input logic [15:0] x, input logic [15:0] y);
      logic [EW-1:0] e;
      string nm;
      nm = $sformatf("dut%0d_%s", inst, kind ? "update_done" : "cent");
      n_cmp++;
      if (qsize(inst) == 0) begin
         n_bad++;
         $display("FAIL %s unexpected: got idx %0d empty %0b x %h y %h at cycle %0d, required no output",
                  nm, idx, emp, x, y, cyc);
         return;
      end
      case (inst)
         0:       e = exp_qa.pop_front();
         1:       e = exp_qb.pop_front();
         default: e = exp_qc.pop_front();
      endcase
      if (kind !== e[67] || 32'(cyc) !== e[31:0] ||
          (!kind && (idx !== e[66:65] || emp !== e[64] || x !== e[63:48] || y !== e[47:32]))) begin
         n_bad++;
         $display("FAIL %s: got kind %0d idx %0d empty %0b x %h y %h cycle %0d, required kind %0d idx %0d empty %0b x %h y %h cycle %0d",
                  nm, kind, idx, emp, x, y, cyc, e[67], e[66:65], e[64], e[63:48], e[47:32], e[31:0]);
      end
   endtask

   // Monitor: compares every presented output against the expected queue.
   always @(negedge clk) begin
      if (a_cv === 1'b1) check_ev(0, 1'b0, a_idx, a_emp, a_x, a_y);
      if (a_ud === 1'b1) check_ev(0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
      if (b_cv === 1'b1) check_ev(1, 1'b0, b_idx, b_emp, b_x, b_y);
      if (b_ud === 1'b1) check_ev(1, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
      if (c_cv === 1'b1) check_ev(2, 1'b0, c_idx, c_emp, c_x, c_y);
      if (c_ud === 1'b1) check_ev(2, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, got, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int inst, input logic [15:0] x, input logic [15:0] y,
                       input logic [1:0] c, input logic e);
      pt_x = x; pt_y = y; pt_cl = c;
      pv[inst] = 1'b1;
      ep[inst] = e;
      tick();
      pv[inst] = 1'b0;
      ep[inst] = 1'b0;
   endtask

   // base is chosen so that cycle T+k of the epoch is observed with cyc == base+k.
   task automatic epoch(input int inst, output int base);
      base = cyc;
      ep[inst] = 1'b1;
      tick();
      ep[inst] = 1'b0;
   endtask

   task automatic drain(input int inst, input int budget);
      int b;
      b = budget;
      while (qsize(inst) != 0 && b > 0) begin
         @(negedge clk);
         b--;
      end
      chk($sformatf("dut%0d_pending_outputs", inst), 32'(qsize(inst)), 32'd0);
      tick();
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, "_busy"},        {31'd0, a_busy}, 32'd0);
      chk({tag, "_cent_valid"},  {31'd0, a_cv},   32'd0);
      chk({tag, "_cent_idx"},    {30'd0, a_idx},  32'd0);
      chk({tag, "_cent_x"},      {16'd0, a_x},    32'd0);
      chk({tag, "_cent_y"},      {16'd0, a_y},    32'd0);
      chk({tag, "_cent_empty"},  {31'd0, a_emp},  32'd0);
      chk({tag, "_update_done"}, {31'd0, a_ud},   32'd0);
      chk({tag, "_overflow"},    {31'd0, a_ov},   32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b;
      rst_v = 3'b111; pv = '0; ep = '0;
      pt_x = '0; pt_y = '0; pt_cl = '0;
      repeat (3) tick();
      rst_v = 3'b000;
      chk_a_zero("reset");
      chk("reset_b_overflow", {31'd0, b_ov}, 32'd0);

      // Mixed epoch: clusters 0,1,3 populated, cluster 2 empty.
      send(0, 16'h0200, 16'h0200, 2'd0, 1'b0);
      send(0, 16'h0240, 16'h0220, 2'd0, 1'b0);
      send(0, 16'h0680, 16'h0600, 2'd1, 1'b0);
      send(0, 16'h0100, 16'h0800, 2'd3, 1'b0);
      send(0, 16'h0100, 16'h0800, 2'd3, 1'b0);
      send(0, 16'h0101, 16'h0800, 2'd3, 1'b0);
      epoch(0, b);
      chk("t1_busy_after_epoch", {31'd0, a_busy}, 32'd1);
      exp_cent(0, 2'd0, 16'h0220, 16'h0210, b + 34);
      exp_cent(0, 2'd1, 16'h0680, 16'h0600, b + 68);
      exp_empty(0, 2'd2, b + 70);
      exp_cent(0, 2'd3, 16'h0100, 16'h0800, b + 104);
      exp_done(0, b + 105);
      drain(0, 200);
      chk("t1_busy_after_done", {31'd0, a_busy}, 32'd0);

      // Point coincident with epoch_done is part of this epoch.
      send(0, 16'h0300, 16'h0300, 2'd0, 1'b0);
      b = cyc;
      send(0, 16'h0100, 16'h0100, 2'd0, 1'b1);
      exp_cent(0, 2'd0, 16'h0200, 16'h0200, b + 34);
      exp_empty(0, 2'd1, b + 36);
      exp_empty(0, 2'd2, b + 38);
      exp_empty(0, 2'd3, b + 40);
      exp_done(0, b + 41);
      // Points and an epoch pulse while busy must be dropped.
      for (int i = 0; i < 10; i++) send(0, 16'h1000, 16'h2000, 2'(i), i == 5);
      drain(0, 200);

      // Epoch with no points: four empty centroids, two cycles each.
      epoch(0, b);
      exp_empty(0, 2'd0, b + 2);
      exp_empty(0, 2'd1, b + 4);
      exp_empty(0, 2'd2, b + 6);
      exp_empty(0, 2'd3, b + 8);
      exp_done(0, b + 9);
      drain(0, 50);

      // Reset in the middle of a division.
      send(0, 16'h0700, 16'h0700, 2'd0, 1'b0);
      epoch(0, b);
      repeat (10) tick();
      rst_v[0] = 1'b1;
      tick();
      chk_a_zero("mid_div_reset");
      rst_v[0] = 1'b0;
      send(0, 16'h0500, 16'h0400, 2'd2, 1'b0);
      epoch(0, b);
      exp_empty(0, 2'd0, b + 2);
      exp_empty(0, 2'd1, b + 4);
      exp_cent(0, 2'd2, 16'h0500, 16'h0400, b + 38);
      exp_empty(0, 2'd3, b + 40);
      exp_done(0, b + 41);
      drain(0, 100);

      // Count saturation with CNT_W = 2 (18 divider iterations).
      send(1, 16'h0100, 16'h0200, 2'd1, 1'b0);
      send(1, 16'h0200, 16'h0300, 2'd1, 1'b0);
      send(1, 16'h0300, 16'h0400, 2'd1, 1'b0);
      chk("sat_overflow_before", {31'd0, b_ov}, 32'd0);
      send(1, 16'h0400, 16'h0500, 2'd1, 1'b0);
      chk("sat_overflow_set", {31'd0, b_ov}, 32'd1);
      epoch(1, b);
      exp_empty(1, 2'd0, b + 2);
      exp_cent(1, 2'd1, 16'h0200, 16'h0300, b + 22);
      exp_empty(1, 2'd2, b + 24);
      exp_empty(1, 2'd3, b + 26);
      exp_done(1, b + 27);
      drain(1, 100);
      chk("sat_overflow_after_done", {31'd0, b_ov}, 32'd1);
      rst_v[1] = 1'b1;
      tick();
      rst_v[1] = 1'b0;
      chk("sat_overflow_after_rst", {31'd0, b_ov}, 32'd0);

      // K = 3: cluster index 3 is ignored, only 0..2 are emitted.
      send(2, 16'h0100, 16'h0100, 2'd0, 1'b0);
      send(2, 16'h0900, 16'h0900, 2'd3, 1'b0);
      send(2, 16'h0300, 16'h0500, 2'd2, 1'b0);
      epoch(2, b);
      exp_cent(2, 2'd0, 16'h0100, 16'h0100, b + 34);
      exp_empty(2, 2'd1, b + 36);
      exp_cent(2, 2'd2, 16'h0300, 16'h0500, b + 70);
      exp_done(2, b + 71);
      drain(2, 200);
      chk("k3_overflow", {31'd0, c_ov}, 32'd0);

      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
